// File: rtl/adder_pkg.sv
// Shared types and constants for the sliced multi-cycle address adder.
// The flag indices give the bit positions inside the {Z,N,H,C} nibble.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    ADDS = 2'd1,
    INC  = 2'd2,
    DEC  = 2'd3
  } add_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  // Only the two add modes update the CPU flag register.
  function automatic logic is_flag_mode(input add_mode_t m);
    return (m == ADD) || (m == ADDS);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry-in, giving sum, carry-out and
// the half-carry out of bit SLICE/2-1.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] sum_o,
  output logic             c_o,
  output logic             h_o
);

  localparam int HALF = SLICE / 2;

  logic [SLICE:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i} + (SLICE+1)'(c_i);
  assign sum_o = full[SLICE-1:0];
  assign c_o   = full[SLICE];
  // The carry into bit HALF is recovered from that bit's operands and sum.
  assign h_o   = a_i[HALF] ^ b_i[HALF] ^ full[HALF];

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle address adder: one SLICE-bit slice per clock, low slice first,
// with a valid/ready request side and a one-cycle result pulse.
module adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  add_mode_t        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       f,
  output logic             flag_en
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  add_mode_t       mode_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, y_q;
  logic            carry_q, h_q, c_q;
  logic [3:0]      f_q;
  logic            flag_en_q;

  logic [WIDTH-1:0] b_eff, res_d;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             co_sl, h_sl, h_d, c_d, last;
  logic [CW-1:0]    flag_idx;
  logic [3:0]       f_d;
  int               base;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_eff = b;
    unique case (mode)
      ADD:  b_eff = b;
      ADDS: b_eff = {{(WIDTH-SLICE){b[SLICE-1]}}, b[SLICE-1:0]};
      INC:  b_eff = WIDTH'(1);
      DEC:  b_eff = '1;
      default: b_eff = b;
    endcase
  end

  always_comb begin
    base = int'(cnt_q) * SLICE;
    a_sl = a_q[base +: SLICE];
    b_sl = b_q[base +: SLICE];
  end

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .c_i   (carry_q),
    .sum_o (sum_sl),
    .c_o   (co_sl),
    .h_o   (h_sl)
  );

  // ADD reports flags from the top slice, ADDS from the bottom slice.
  assign flag_idx = (mode_q == ADD) ? CW'(NSLICE-1) : '0;
  assign last     = (cnt_q == CW'(NSLICE-1));

  always_comb begin
    res_d = res_q;
    res_d[base +: SLICE] = sum_sl;
    h_d = (cnt_q == flag_idx) ? h_sl  : h_q;
    c_d = (cnt_q == flag_idx) ? co_sl : c_q;
    f_d = '0;
    if (is_flag_mode(mode_q)) begin
      f_d[FLAG_H] = h_d;
      f_d[FLAG_C] = c_d;
    end
  end

  // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= ADD;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      h_q       <= 1'b0;
      c_q       <= 1'b0;
      y_q       <= '0;
      f_q       <= '0;
      flag_en_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_eff;
            mode_q  <= mode;
            carry_q <= 1'b0;
            h_q     <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= co_sl;
          h_q     <= h_d;
          c_q     <= c_d;
          if (last) begin
            cnt_q     <= '0;
            state_q   <= DONE;
            y_q       <= res_d;
            f_q       <= f_d;
            flag_en_q <= is_flag_mode(mode_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q != RUN);
  assign out_valid = (state_q == DONE) && !flush;
  assign y         = y_q;
  assign f         = f_q;
  assign flag_en   = flag_en_q;

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq: default 16/8 instance and a 32/4 instance,
// covering modes, flags, back-to-back throughput, reset and flush aborts.
module tb_adder_seq;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        iv0 = 1'b0, rdy0, ov0, fe0;
  add_mode_t   mode0 = ADD;
  logic [15:0] a0 = '0, b0 = '0, y0;
  logic [3:0]  f0;

  logic        iv1 = 1'b0, rdy1, ov1, fe1;
  add_mode_t   mode1 = ADD;
  logic [31:0] a1 = '0, b1 = '0, y1;
  logic [3:0]  f1;

  int tests = 0;
  int fails = 0;

  adder_seq u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(rdy0),
    .mode(mode0), .a(a0), .b(b0), .out_valid(ov0), .y(y0), .f(f0), .flag_en(fe0)
  );

  adder_seq #(.WIDTH(32), .SLICE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(rdy1),
    .mode(mode1), .a(a1), .b(b1), .out_valid(ov1), .y(y1), .f(f1), .flag_en(fe1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input add_mode_t m, input logic [63:0] av,
                       input logic [63:0] bv, input logic v);
    if (sel) begin mode1 = m; a1 = av[31:0]; b1 = bv[31:0]; iv1 = v; end
    else     begin mode0 = m; a0 = av[15:0]; b0 = bv[15:0]; iv0 = v; end
  endtask

  function automatic logic ov(input bit sel);   return sel ? ov1 : ov0;     endfunction
  function automatic logic rdy(input bit sel);  return sel ? rdy1 : rdy0;   endfunction
  function automatic logic [63:0] yv(input bit sel); return sel ? 64'(y1) : 64'(y0); endfunction
  function automatic logic [3:0] fv(input bit sel);  return sel ? f1 : f0;  endfunction
  function automatic logic fe(input bit sel);   return sel ? fe1 : fe0;     endfunction

  // Latency counts the accept edge as edge 1: NSLICE+1 edges in all.
  task automatic run(input bit sel, input add_mode_t m, input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] ey, input logic [3:0] ef, input logic efe, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(rdy(sel)), 64'd1);
    drive(sel, m, av, bv, 1'b1);
    @(posedge clk); #1;
    drive(sel, m, av, bv, 1'b0);
    lat = 1;
    while (!ov(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), sel ? 64'd9 : 64'd3);
    check({tag, " y"}, yv(sel), ey);
    check({tag, " f"}, 64'(fv(sel)), 64'(ef));
    check({tag, " flag_en"}, 64'(fe(sel)), 64'(efe));
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(ov(sel)), 64'd0);
  endtask

  // Abort one cycle after accept with reset (use_rst) or flush.
  task automatic abort(input bit sel, input bit use_rst, input logic [63:0] prev_y, input string tag);
    int pulses;
    @(negedge clk);
    drive(sel, ADD, 64'h1, 64'h1, 1'b1);
    @(posedge clk); #1;
    drive(sel, ADD, 64'h1, 64'h1, 1'b0);
    @(negedge clk);
    if (use_rst) rst_n = 1'b0; else flush = 1'b1;
    #1;
    check({tag, " ov during abort"}, 64'(ov(sel)), 64'd0);
    @(posedge clk); #1;
    check({tag, " in_ready"}, 64'(rdy(sel)), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov(sel)) pulses++;
    end
    check({tag, " no result"}, 64'(pulses), 64'd0);
    check({tag, " y after abort"}, yv(sel), use_rst ? 64'd0 : prev_y);
  endtask

  initial begin
    int gap;
    #1;
    check("reset in_ready", 64'(rdy0), 64'd1);
    check("reset out_valid", 64'(ov0), 64'd0);
    check("reset y", 64'(y0), 64'd0);
    check("reset f", 64'(f0), 64'd0);
    check("reset flag_en", 64'(fe0), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(0, ADD,  64'h0FFF, 64'h0001, 64'h1000, 4'b0010, 1'b1, "add_h");
    run(0, ADD,  64'h8000, 64'h8000, 64'h0000, 4'b0001, 1'b1, "add_c");
    run(0, ADD,  64'hFFFF, 64'h0001, 64'h0000, 4'b0011, 1'b1, "add_wrap");
    run(0, ADD,  64'h1234, 64'h5678, 64'h68AC, 4'b0000, 1'b1, "add_plain");
    run(0, ADDS, 64'hFFF8, 64'hAB08, 64'h0000, 4'b0011, 1'b1, "adds_pos");
    run(0, ADDS, 64'h0005, 64'h00FE, 64'h0003, 4'b0011, 1'b1, "adds_neg");
    run(0, ADDS, 64'h1000, 64'h0080, 64'h0F80, 4'b0000, 1'b1, "adds_min");
    run(0, INC,  64'hFFFF, 64'h1234, 64'h0000, 4'b0000, 1'b0, "inc_wrap");
    run(0, DEC,  64'h0000, 64'h1234, 64'hFFFF, 4'b0000, 1'b0, "dec_wrap");

    // Back-to-back: second request held on in_valid through RUN.
    @(negedge clk);
    drive(0, ADD, 64'h0102, 64'h0304, 1'b1);
    @(posedge clk); #1;
    drive(0, DEC, 64'h8000, 64'h0, 1'b1);
    gap = 1;
    while (!ov0 && gap < 40) begin @(posedge clk); #1; gap++; end
    check("b2b first latency", 64'(gap), 64'd3);
    check("b2b first y", 64'(y0), 64'h0406);
    @(posedge clk); #1;
    drive(0, DEC, 64'h8000, 64'h0, 1'b0);
    gap = 1;
    while (!ov0 && gap < 40) begin @(posedge clk); #1; gap++; end
    check("b2b spacing", 64'(gap), 64'd3);
    check("b2b second y", 64'(y0), 64'h7FFF);
    check("b2b second flag_en", 64'(fe0), 64'd0);

    // flush with in_valid in IDLE: request not accepted.
    @(posedge clk); #1;
    @(negedge clk);
    drive(0, ADD, 64'h1, 64'h1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush+valid in_ready", 64'(rdy0), 64'd1);
    drive(0, ADD, 64'h1, 64'h1, 1'b0);
    flush = 1'b0;

    abort(0, 1'b0, 64'h7FFF, "flush16");
    run(0, ADD, 64'h00FF, 64'h0001, 64'h0100, 4'b0000, 1'b1, "after_flush16");
    abort(0, 1'b1, 64'h0, "rst16");
    run(0, ADD, 64'h0FFF, 64'h0001, 64'h1000, 4'b0010, 1'b1, "after_rst16");

    run(1, ADD,  64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 4'b0010, 1'b1, "w32_add_h");
    run(1, ADD,  64'hFFFF_FFFF, 64'h1, 64'h0000_0000, 4'b0011, 1'b1, "w32_add_wrap");
    run(1, ADDS, 64'h0000_0007, 64'h9, 64'h0000_0000, 4'b0011, 1'b1, "w32_adds");
    abort(1, 1'b0, 64'h0, "flush32");
    run(1, INC,  64'h0000_FFFF, 64'h0, 64'h0001_0000, 4'b0000, 1'b0, "w32_inc");
    abort(1, 1'b1, 64'h0, "rst32");
    run(1, ADD,  64'h1234_5678, 64'h1111_1111, 64'h2345_6789, 4'b0000, 1'b1, "w32_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised, sliced, multi-cycle successor to the CPU's combinational 16-bit address adder.
- Adds SLICE bits per clock over WIDTH/SLICE cycles, mirroring the SM83 low-byte-then-high-byte 16-bit datapath.
- Supports four modes: register-pair add, signed-offset add (SP+e8 style), increment and decrement.
- Sits beside the main ALU in the CPU core. Driven by the sequencer through a valid/ready handshake; delivers result plus {Z,N,H,C} flags.

Parameters:
- WIDTH, 16: operand/result width; must be a multiple of SLICE.
- SLICE, 8: bits processed per cycle; even, >= 2.
- NSLICE, WIDTH/SLICE: derived local constant; latency in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns to IDLE.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- mode  input  2  adder_pkg::add_mode_t: ADD, ADDS, INC, DEC.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand. ADD uses all bits; ADDS uses b[SLICE-1:0] sign-extended; INC/DEC ignore b.
- out_valid  output  1  one-cycle pulse: y/f valid.
- y  output  WIDTH  result, modulo 2^WIDTH.
- f  output  4  {Z,N,H,C}; Z=N=0 always.
- flag_en  output  1  1 when f must be written to the flag register (ADD, ADDS); 0 for INC/DEC.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slice counter=0.
  - y=0, f=0, flag_en=0, out_valid=0, in_ready=1.
- States: IDLE, RUN, DONE.
  - in_ready=1 in IDLE and DONE; 0 in RUN.
- Accept: in_valid && in_ready at a rising edge.
  - Latch a, the effective b and mode.
  - Effective b per mode: ADD=b; ADDS=sext(b[SLICE-1:0]); INC=1; DEC=all ones.
  - Carry register=0, counter=0; go to RUN.
- RUN, one slice per cycle, slice i = counter:
  - sum = a_slice + b_slice + carry, SLICE+1 bits wide.
  - Store sum[SLICE-1:0] into y slice i; carry <= sum[SLICE].
  - Half-carry of slice i = carry out of bit SLICE/2-1 within the slice, including carry-in.
  - Flag slice: ADD uses slice NSLICE-1; ADDS uses slice 0. For WIDTH=16 this gives H=bit 11, C=bit 15 for ADD, and H=bit 3, C=bit 7 for ADDS.
  - When i is the flag slice, capture H and C.
  - Counter wraps at NSLICE-1; then go to DONE.
- DONE:
  - out_valid=1 for exactly this cycle.
  - f={2'b00,H,C}; flag_en=1 for ADD/ADDS, 0 for INC/DEC (f then holds 0).
  - Accept in DONE is allowed: goes straight to RUN, giving back-to-back throughput of one result per NSLICE+1 cycles. Otherwise go to IDLE.
- Output holding: y, f, flag_en hold their values until the next DONE. Intermediate slices of y may change during RUN; consumers sample only on out_valid.
- Latency: out_valid asserts NSLICE+1 rising edges after the accept edge (3 for 16/8 defaults).
- Wrap-around: all arithmetic is modulo 2^WIDTH; the final carry feeds only C, and only when the flag slice is the top slice.
- flush:
  - Has priority over every other event; out_valid is forced 0 that cycle and no result is produced.
  - State goes to IDLE; y/f keep their previous values.
  - flush together with in_valid: the request is not accepted.
- Reset mid-RUN: immediate return to reset values; the partial result is discarded.
- in_valid while in RUN: ignored, because in_ready=0. The requester must hold it.

Decomposition:
- adder_pkg holds:
  - add_mode_t enum {ADD=2'd0, ADDS=2'd1, INC=2'd2, DEC=2'd3};
  - state_t enum {IDLE, RUN, DONE};
  - the flag bit-index constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0.
- One sub-module, adder_slice: combinational SLICE-bit add with carry-in, producing sum, carry-out and half-carry. Instantiated once and time-multiplexed by the counter.

Test Plan:
- ADD a=16'h0FFF, b=16'h0001 -> y=16'h1000, f=4'b0010, flag_en=1, out_valid exactly 3 edges after accept.
- ADD a=16'h8000, b=16'h8000 -> y=16'h0000, f=4'b0001. ADD a=16'hFFFF, b=16'h0001 -> y=0, f=4'b0011.
- ADDS a=16'hFFF8, b=8'h08 -> y=16'h0000, f=4'b0011; ADDS a=16'h0005, b=8'hFE -> y=16'h0003, f=4'b0011; ADDS a=16'h1000, b=8'h80 -> y=16'h0F80, f=4'b0000.
- INC a=16'hFFFF -> y=16'h0000, flag_en=0, f=0; DEC a=16'h0000 -> y=16'hFFFF, flag_en=0.
- Back-to-back: second request held on in_valid through RUN, accepted in DONE -> two out_valid pulses 3 cycles apart, each with correct y.
- Control: rst_n low, and separately flush, one cycle after accept -> no out_valid, in_ready=1 the next cycle, then a fresh ADD completes correctly. Repeat with WIDTH=32, SLICE=4 (latency 8+1).
